// File: rtl/lsu_ctrl.sv
// Load/store unit between the memory stage and a word-organised data memory.
// Handles RV32I byte/half/word loads and stores; sub-word stores use read-modify-write.
module lsu_ctrl #(
  parameter int N = 32,
  parameter int M = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic         st,
  input  logic [2:0]   funct3,
  input  logic [31:0]  addr,
  input  logic [N-1:0] wdata,
  output logic         ready,
  output logic         done,
  output logic         err,
  output logic [N-1:0] rdata,
  output logic [M-1:0] mem_adrs,
  output logic [N-1:0] mem_data_w,
  output logic         mem_WE,
  input  logic [N-1:0] mem_data_r
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] STORE  = 3'd2;
  localparam logic [2:0] RMW_RD = 3'd3;
  localparam logic [2:0] RMW_WR = 3'd4;

  logic [2:0]   state;
  logic [M-1:0] addr_q;
  logic [N-1:0] data_q;
  logic [2:0]   f3_q;

  logic         illegal;
  logic         misaligned;
  logic [7:0]   byte_lane;
  logic [15:0]  half_lane;
  logic [N-1:0] load_val;
  logic [N-1:0] merged;

  // Upper address bits wrap within the memory and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:M];

  always_comb begin
    illegal = 1'b0;
    if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7)
      illegal = 1'b1;
    if (st && funct3[2])
      illegal = 1'b1;
  end

  always_comb begin
    misaligned = 1'b0;
    if (funct3[1:0] == 2'd1 && addr[0])
      misaligned = 1'b1;
    if (funct3 == 3'd2 && addr[1:0] != 2'd0)
      misaligned = 1'b1;
  end

  always_comb begin
    byte_lane = '0;
    case (addr_q[1:0])
      2'd0: byte_lane = mem_data_r[7:0];
      2'd1: byte_lane = mem_data_r[15:8];
      2'd2: byte_lane = mem_data_r[23:16];
      2'd3: byte_lane = mem_data_r[31:24];
      default: byte_lane = '0;
    endcase
    half_lane = addr_q[1] ? mem_data_r[31:16] : mem_data_r[15:0];
  end

  always_comb begin
    load_val = mem_data_r;
    case (f3_q)
      3'd0: load_val = {{(N-8){byte_lane[7]}}, byte_lane};
      3'd4: load_val = {{(N-8){1'b0}}, byte_lane};
      3'd1: load_val = {{(N-16){half_lane[15]}}, half_lane};
      3'd5: load_val = {{(N-16){1'b0}}, half_lane};
      default: load_val = mem_data_r;
    endcase
  end

  // Replace only the addressed lane of the word just read from memory.
  always_comb begin
    merged = mem_data_r;
    if (f3_q[1:0] == 2'd0)
      merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done   <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
      addr_q <= '0;
      data_q <= '0;
      f3_q   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q <= addr[M-1:0];
            data_q <= wdata;
            f3_q   <= funct3;
            if (illegal || misaligned) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else if (!st) begin
              state <= LOAD;
            end else if (funct3 == 3'd2) begin
              state <= STORE;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          rdata <= load_val;
          done  <= 1'b1;
          state <= IDLE;
        end
        STORE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        RMW_RD: begin
          data_q <= merged;
          state  <= RMW_WR;
        end
        RMW_WR: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready      = (state == IDLE);
  assign mem_WE     = (state == STORE) || (state == RMW_WR);
  assign mem_adrs   = {addr_q[M-1:2], 2'b00};
  assign mem_data_w = data_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus queues expected completions,
// a negedge monitor pops and compares them whenever done pulses.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        st = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, done, err, mem_WE;
  logic [31:0] rdata, mem_data_w, mem_data_r;
  logic [9:0]  mem_adrs;

  logic [31:0] mem [0:255];

  typedef struct packed {
    logic        e;
    logic [31:0] d;
  } exp_t;
  exp_t sb_q[$];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned we_cnt = 0;
  logic [31:0] last_rd = '0;

  lsu_ctrl #(.N(32), .M(10)) dut (
    .clk(clk), .rst(rst), .req(req), .st(st), .funct3(funct3),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .mem_adrs(mem_adrs), .mem_data_w(mem_data_w),
    .mem_WE(mem_WE), .mem_data_r(mem_data_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_WE) mem[mem_adrs[9:2]] <= mem_data_w;
  assign mem_data_r = mem[mem_adrs[9:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mem_WE) we_cnt++;
    if (!rst && err && !done) begin
      n_bad++;
      $display("FAIL err_without_done: got 1 expected 0");
    end
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end else begin
        e = sb_q.pop_front();
        chk("done_err", {31'b0, err}, {31'b0, e.e});
        chk("done_rdata", rdata, e.d);
      end
    end
  end

  // e_cyc: negedges from the accept edge until done is seen (1 = done right after accept).
  task automatic op(input string nm, input logic s, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic e_err, input logic [31:0] e_rd,
                    input int unsigned e_cyc, input int unsigned e_we);
    int unsigned cyc;
    int unsigned we0;
    bit got;
    cyc = 0;
    while (!ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_ready"}, {31'b0, ready}, 32'd1);
    if (!s && !e_err) last_rd = e_rd;
    sb_q.push_back('{e: e_err, d: last_rd});
    we0 = we_cnt;
    st = s; funct3 = f3; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    cyc = 0;
    got = 0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1;
    end
    chk({nm, "_latency"}, cyc, e_cyc);
    chk({nm, "_we_count"}, we_cnt - we0, e_we);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_we", {31'b0, mem_WE}, 32'd0);
    chk("rst_adrs", {22'b0, mem_adrs}, 32'h0);

    op("sw_010",   1, 3'd2, 32'h010, 32'h11223344, 0, 32'h0,        2, 1);
    op("lw_010",   0, 3'd2, 32'h010, 32'h0,        0, 32'h11223344, 2, 0);
    op("lb_013",   0, 3'd0, 32'h013, 32'h0,        0, 32'h00000011, 2, 0);
    op("lbu_010",  0, 3'd4, 32'h010, 32'h0,        0, 32'h00000044, 2, 0);

    op("sw_020",   1, 3'd2, 32'h020, 32'h80FF7F01, 0, 32'h0,        2, 1);
    op("lb_021",   0, 3'd0, 32'h021, 32'h0,        0, 32'h0000007F, 2, 0);
    op("lb_022",   0, 3'd0, 32'h022, 32'h0,        0, 32'hFFFFFFFF, 2, 0);
    op("lbu_022",  0, 3'd4, 32'h022, 32'h0,        0, 32'h000000FF, 2, 0);
    op("lh_022",   0, 3'd1, 32'h022, 32'h0,        0, 32'hFFFF80FF, 2, 0);
    op("lhu_022",  0, 3'd5, 32'h022, 32'h0,        0, 32'h000080FF, 2, 0);
    op("lh_020",   0, 3'd1, 32'h020, 32'h0,        0, 32'h00007F01, 2, 0);

    op("sb_011",   1, 3'd0, 32'h011, 32'h000000AB, 0, 32'h0,        3, 1);
    op("lw_sb",    0, 3'd2, 32'h010, 32'h0,        0, 32'h1122AB44, 2, 0);
    op("sh_012",   1, 3'd1, 32'h012, 32'h0000CAFE, 0, 32'h0,        3, 1);
    op("lw_sh",    0, 3'd2, 32'h010, 32'h0,        0, 32'hCAFEAB44, 2, 0);

    op("lw_mis",   0, 3'd2, 32'h012, 32'h0,        1, 32'h0,        1, 0);
    op("sh_mis",   1, 3'd1, 32'h011, 32'h12345678, 1, 32'h0,        1, 0);
    op("f3_3",     0, 3'd3, 32'h010, 32'h0,        1, 32'h0,        1, 0);
    op("sbu_ill",  1, 3'd4, 32'h010, 32'h000000FF, 1, 32'h0,        1, 0);
    op("lw_after_err", 0, 3'd2, 32'h010, 32'h0,    0, 32'hCAFEAB44, 2, 0);

    // Reset while the sub-word store sits in its read phase.
    begin
      int unsigned we0;
      @(negedge clk);
      we0 = we_cnt;
      st = 1'b1; funct3 = 3'd0; addr = 32'h010; wdata = 32'h000000FF; req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready", {31'b0, ready}, 32'd1);
      chk("midrst_done", {31'b0, done}, 32'd0);
      repeat (2) @(negedge clk);
      chk("midrst_we", we_cnt - we0, 32'd0);
      last_rd = '0;
    end
    op("lw_post_rst", 0, 3'd2, 32'h010, 32'h0,     0, 32'hCAFEAB44, 2, 0);
    op("lw_wrap",     0, 3'd2, 32'h410, 32'h0,     0, 32'hCAFEAB44, 2, 0);

    op("b2b_lw",   0, 3'd2, 32'h020, 32'h0,        0, 32'h80FF7F01, 2, 0);
    op("b2b_sw",   1, 3'd2, 32'h030, 32'hDEADBEEF, 0, 32'h0,        2, 1);
    op("b2b_sb",   1, 3'd0, 32'h031, 32'h0000005A, 0, 32'h0,        3, 1);
    op("b2b_lbu",  0, 3'd4, 32'h031, 32'h0,        0, 32'h0000005A, 2, 0);
    op("b2b_lw2",  0, 3'd2, 32'h030, 32'h0,        0, 32'hDEAD5AEF, 2, 0);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
